alu_exec_unit: RTL and testbench



---
 rtl/alu_exec_unit.sv | 166 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute stage sitting after the 8x8 register file.
// On START it latches the operands, opcode and destination, computes the
// result, then drives a one-cycle LD/DONE writeback with D_out, DR and the
// Z/N/C flags.
// Optional feature macro: ALU_MUL_EN. When defined, OP=111 is an 8-cycle
// shift-add multiply. When undefined, OP=111 is MOV (result=B, C=0) on the
// single-cycle path.
module alu_exec_unit #(
  parameter int WIDTH = 8,
  parameter int RADDR = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [RADDR-1:0] DR_IN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic             LD,
  output logic [RADDR-1:0] DR,
  output logic [WIDTH-1:0] D_out,
  output logic             Z,
  output logic             N,
  output logic             C
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
`ifdef ALU_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b111;
  localparam int         CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
`ifdef ALU_MUL_EN
    MUL  = 2'd3,
`endif
    WB   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [2:0]       op_reg;
  logic [RADDR-1:0] dr_reg;
  logic             ld_q;

  // Carry/borrow/shift-out travels in the extra top bit of alu_full.
  logic [WIDTH:0]   alu_full;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [CW-1:0]      cnt;

  // One shift-add step: add A shifted by the current bit position when that B bit is set.
  assign acc_next = acc + (b_reg[cnt] ? ({{WIDTH{1'b0}}, a_reg} << cnt) : '0);
`endif

  assign BUSY = (state != IDLE);
  assign LD   = ld_q;
  assign DONE = ld_q;

  // Single-cycle ALU datapath on the latched operands.
  always_comb begin
    // NOTE: default assignment first so every path drives alu_full and no latch is inferred.
    alu_full = '0;
    unique case (op_reg)
      OP_ADD:  alu_full = {1'b0, a_reg} + {1'b0, b_reg};
      OP_SUB:  alu_full = {1'b0, a_reg} - {1'b0, b_reg};
      OP_AND:  alu_full = {1'b0, a_reg & b_reg};
      OP_OR:   alu_full = {1'b0, a_reg | b_reg};
      OP_XOR:  alu_full = {1'b0, a_reg ^ b_reg};
      OP_SHL:  alu_full = {a_reg[WIDTH-1], a_reg << 1};
      OP_SHR:  alu_full = {a_reg[0], a_reg >> 1};
      default: alu_full = {1'b0, b_reg};
    endcase
  end

  assign alu_res = alu_full[WIDTH-1:0];
  assign alu_c   = alu_full[WIDTH];

  // Control FSM with registered writeback outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      op_reg <= '0;
      dr_reg <= '0;
      ld_q   <= 1'b0;
      DR     <= '0;
      D_out  <= '0;
      Z      <= 1'b0;
      N      <= 1'b0;
      C      <= 1'b0;
`ifdef ALU_MUL_EN
      acc    <= '0;
      cnt    <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      ld_q <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            a_reg  <= A;
            b_reg  <= B;
            op_reg <= OP;
            dr_reg <= DR_IN;
`ifdef ALU_MUL_EN
            acc    <= '0;
            cnt    <= '0;
            state  <= (OP == OP_MUL) ? MUL : EXEC;
`else
            state  <= EXEC;
`endif
          end
        end
        EXEC: begin
          D_out <= alu_res;
          Z     <= (alu_res == '0);
          N     <= alu_res[WIDTH-1];
          C     <= alu_c;
          DR    <= dr_reg;
          ld_q  <= 1'b1;
          state <= WB;
        end
`ifdef ALU_MUL_EN
        MUL: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            D_out <= acc_next[WIDTH-1:0];
            Z     <= (acc_next[WIDTH-1:0] == '0);
            N     <= acc_next[WIDTH-1];
            C     <= |acc_next[2*WIDTH-1:WIDTH];
            DR    <= dr_reg;
            ld_q  <= 1'b1;
            state <= WB;
          end
        end
`endif
        WB: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed testbench for alu_exec_unit. Covers both builds: the multiply
// cases run when ALU_MUL_EN is defined, the MOV case when it is not.
module tb_alu_exec_unit;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       START;
  logic [2:0] OP;
  logic [2:0] DR_IN;
  logic [7:0] A;
  logic [7:0] B;
  logic       BUSY;
  logic       DONE;
  logic       LD;
  logic [2:0] DR;
  logic [7:0] D_out;
  logic       Z;
  logic       N;
  logic       C;

  int checks   = 0;
  int failures = 0;

  alu_exec_unit #(.WIDTH(8), .RADDR(3)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .OP(OP), .DR_IN(DR_IN),
    .A(A), .B(B), .BUSY(BUSY), .DONE(DONE), .LD(LD), .DR(DR),
    .D_out(D_out), .Z(Z), .N(N), .C(C)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Issue one op at edge k, scramble the inputs afterwards, then wait for LD.
  // exp_lat is the number of edges after edge k until LD is seen high.
  // poke_at >= 0 pulses START with a different op while the unit is busy.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [2:0] dr, input int exp_lat,
                        input logic [7:0] exp_d, input logic exp_z, input logic exp_n,
                        input logic exp_c, input int poke_at);
    int   lat;
    logic busy_ok;
    @(negedge CLK);
    START = 1'b1; OP = op; A = a; B = b; DR_IN = dr;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0; OP = ~op; A = ~a; B = ~b; DR_IN = ~dr;
    busy_ok = BUSY;
    lat = 0;
    while (!LD && lat < 20) begin
      if (lat == poke_at) begin
        START = 1'b1; OP = 3'b000; A = 8'h01; B = 8'h01; DR_IN = 3'd7;
      end else begin
        START = 1'b0;
      end
      @(posedge CLK);
      @(negedge CLK);
      lat++;
      if (!BUSY) busy_ok = 1'b0;
    end
    START = 1'b0;
    check({tag, " ld"},     16'(LD), 16'(1));
    check({tag, " lat"},    16'(lat), 16'(exp_lat));
    check({tag, " done"},   16'(DONE), 16'(1));
    check({tag, " busy"},   16'(busy_ok), 16'(1));
    check({tag, " d_out"},  16'(D_out), 16'(exp_d));
    check({tag, " dr"},     16'(DR), 16'(dr));
    check({tag, " znc"},    16'({Z, N, C}), 16'({exp_z, exp_n, exp_c}));
    @(posedge CLK);
    @(negedge CLK);
    check({tag, " ld_off"}, 16'(LD), 16'(0));
    check({tag, " idle"},   16'(BUSY), 16'(0));
    check({tag, " hold"},   16'(D_out), 16'(exp_d));
  endtask

  initial begin
    int ld_seen;
    RESET = 1'b1; START = 1'b0; OP = '0; DR_IN = '0; A = '0; B = '0;
    #1;
    check("rst busy",  16'(BUSY), 16'(0));
    check("rst ld",    16'({LD, DONE}), 16'(0));
    check("rst d_out", 16'(D_out), 16'(0));
    check("rst dr",    16'(DR), 16'(0));
    check("rst znc",   16'({Z, N, C}), 16'(0));
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;

    //      tag        op      A      B      DR  lat  D_out  Z  N  C  poke
    run_op("add_c",   3'b000, 8'hF0, 8'h20, 3'd3, 1, 8'h10, 0, 0, 1, -1);
    run_op("sub_z",   3'b001, 8'h05, 8'h05, 3'd1, 1, 8'h00, 1, 0, 0, -1);
    run_op("sub_b",   3'b001, 8'h03, 8'h05, 3'd2, 1, 8'hFE, 0, 1, 1, -1);
    run_op("shl",     3'b101, 8'h81, 8'h00, 3'd4, 1, 8'h02, 0, 0, 1, -1);
    run_op("shr",     3'b110, 8'h81, 8'h00, 3'd5, 1, 8'h40, 0, 0, 1, -1);
    run_op("and",     3'b010, 8'hF0, 8'h3C, 3'd6, 1, 8'h30, 0, 0, 0, -1);
    run_op("or",      3'b011, 8'h0F, 8'h80, 3'd7, 1, 8'h8F, 0, 1, 0, -1);
    run_op("xor",     3'b100, 8'hAA, 8'hAA, 3'd0, 1, 8'h00, 1, 0, 0, -1);
    run_op("add_n",   3'b000, 8'h7F, 8'h01, 3'd1, 1, 8'h80, 0, 1, 0, -1);
`ifdef ALU_MUL_EN
    run_op("mul_13x11", 3'b111, 8'd13, 8'd11, 3'd2, 8, 8'h8F, 0, 1, 0, -1);
    run_op("mul_20x20", 3'b111, 8'd20, 8'd20, 3'd3, 8, 8'h90, 0, 1, 1, -1);
    run_op("mul_poke",  3'b111, 8'd13, 8'd11, 3'd4, 8, 8'h8F, 0, 1, 0, 2);
`else
    run_op("mov",       3'b111, 8'h33, 8'h5A, 3'd2, 1, 8'h5A, 0, 0, 0, -1);
    run_op("mov_zero",  3'b111, 8'hFF, 8'h00, 3'd3, 1, 8'h00, 1, 0, 0, -1);
`endif
    // Leave nonzero outputs behind, then reset mid-operation.
    run_op("pre_rst", 3'b011, 8'h80, 8'h01, 3'd5, 1, 8'h81, 0, 1, 0, -1);
    @(negedge CLK);
`ifdef ALU_MUL_EN
    START = 1'b1; OP = 3'b111; A = 8'd3; B = 8'd3; DR_IN = 3'd6;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
`else
    START = 1'b1; OP = 3'b000; A = 8'd1; B = 8'd1; DR_IN = 3'd6;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
`endif
    check("mid busy", 16'(BUSY), 16'(1));
    #1;
    RESET = 1'b1;
    #1;
    check("mr busy",  16'(BUSY), 16'(0));
    check("mr ld",    16'({LD, DONE}), 16'(0));
    check("mr d_out", 16'(D_out), 16'(0));
    check("mr dr",    16'(DR), 16'(0));
    check("mr znc",   16'({Z, N, C}), 16'(0));
    @(negedge CLK);
    RESET = 1'b0;
    ld_seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      if (LD) ld_seen++;
    end
    check("mr no_ld", 16'(ld_seen), 16'(0));
    check("mr idle",  16'(BUSY), 16'(0));

    // Unit must still work after the mid-op reset.
    run_op("post_rst", 3'b000, 8'h01, 8'h02, 3'd7, 1, 8'h03, 0, 0, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
